// File: rtl/seq_ctrl_unit.sv
// Timing-sequence and interrupt-cycle controller: T-state counter, S/R flags, IEN, vectored IRQ entry.
// Optional: define SEQ_IRQ_ROUND_ROBIN_EN for round-robin channel arbitration (default fixed lowest-index).
module seq_ctrl_unit #(
  parameter int unsigned T_STATES     = 16,
  parameter int unsigned IRQ_CH       = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned VEC_BASE     = 0,
  parameter int unsigned VEC_STRIDE   = 2,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           t_clr,
  input  logic                                           halt_req,
  input  logic                                           run_req,
  input  logic                                           ien_set,
  input  logic                                           ien_clr,
  input  logic [IRQ_CH-1:0]                              irq_flag,
  input  logic [IRQ_CH-1:0]                              irq_mask,
  output logic [$clog2(T_STATES)-1:0]                    t_count,
  output logic [T_STATES-1:0]                            t_onehot,
  output logic                                           r_flag,
  output logic                                           running,
  output logic                                           ien,
  output logic [((IRQ_CH > 1) ? $clog2(IRQ_CH) : 1)-1:0] irq_id,
  output logic [ADDR_W-1:0]                              irq_vec,
  output logic [IRQ_CH-1:0]                              int_ack,
  output logic                                           seq_overrun
);

  localparam int unsigned CW = $clog2(T_STATES);
  localparam int unsigned IW = (IRQ_CH > 1) ? $clog2(IRQ_CH) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(T_STATES - 1);

  typedef enum logic [1:0] {
    MODE_HALT,
    MODE_RUN,
    MODE_IRQ
  } mode_t;

  mode_t             state;
  logic [IRQ_CH-1:0] pending;
  logic [IW-1:0]     win_id;
  logic [ADDR_W-1:0] win_vec;
  logic              take_irq;
  logic              r_exit;

`ifdef SEQ_IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Channels at or above the pointer outrank those below it; lowest index wins within each group.
  always_comb begin
    win_id = '0;
    for (int i = int'(IRQ_CH) - 1; i >= 0; i--) begin
      if (pending[i] && (IW'(i) < rr_ptr)) win_id = IW'(i);
    end
    for (int i = int'(IRQ_CH) - 1; i >= 0; i--) begin
      if (pending[i] && (IW'(i) >= rr_ptr)) win_id = IW'(i);
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = int'(IRQ_CH) - 1; i >= 0; i--) begin
      if (pending[i]) win_id = IW'(i);
    end
  end
`endif

  assign pending  = irq_flag & irq_mask;
  assign win_vec  = ADDR_W'(VEC_BASE + 32'(win_id) * VEC_STRIDE);
  assign take_irq = (state == MODE_RUN) && !halt_req && (t_count >= CW'(3)) && ien && (|pending);
  assign r_exit   = (state == MODE_IRQ) && (t_count == CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN_ON_RESET ? MODE_RUN : MODE_HALT;
      running     <= RUN_ON_RESET;
      r_flag      <= 1'b0;
      t_count     <= '0;
      t_onehot    <= T_STATES'(RUN_ON_RESET);
      ien         <= 1'b0;
      irq_id      <= '0;
      irq_vec     <= ADDR_W'(VEC_BASE);
      int_ack     <= '0;
      seq_overrun <= 1'b0;
`ifdef SEQ_IRQ_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      int_ack <= '0;

      if (r_exit)       ien <= 1'b0;
      else if (ien_clr) ien <= 1'b0;
      else if (ien_set) ien <= 1'b1;

      case (state)
        MODE_HALT: begin
          if (run_req) begin
            state    <= MODE_RUN;
            running  <= 1'b1;
            t_onehot <= T_STATES'(1);
          end
        end
        MODE_RUN: begin
          if (halt_req) begin
            state    <= MODE_HALT;
            running  <= 1'b0;
            t_count  <= '0;
            t_onehot <= '0;
          end else if (take_irq) begin
            // Entry always restarts the count so the R cycle runs T0..T2.
            state    <= MODE_IRQ;
            r_flag   <= 1'b1;
            t_count  <= '0;
            t_onehot <= T_STATES'(1);
            irq_id   <= win_id;
            irq_vec  <= win_vec;
          end else if (t_clr) begin
            t_count  <= '0;
            t_onehot <= T_STATES'(1);
          end else if (t_count == T_LAST) begin
            t_count     <= '0;
            t_onehot    <= T_STATES'(1);
            seq_overrun <= 1'b1;
          end else begin
            t_count  <= t_count + CW'(1);
            t_onehot <= t_onehot << 1;
          end
        end
        MODE_IRQ: begin
          if (r_exit) begin
            state    <= MODE_RUN;
            r_flag   <= 1'b0;
            t_count  <= '0;
            t_onehot <= T_STATES'(1);
            int_ack  <= IRQ_CH'(1) << irq_id;
`ifdef SEQ_IRQ_ROUND_ROBIN_EN
            rr_ptr   <= (irq_id == IW'(IRQ_CH - 1)) ? '0 : irq_id + IW'(1);
`endif
          end else begin
            t_count  <= t_count + CW'(1);
            t_onehot <= t_onehot << 1;
          end
        end
        default: begin
          state    <= MODE_HALT;
          running  <= 1'b0;
          r_flag   <= 1'b0;
          t_count  <= '0;
          t_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit at default parameters; expectations follow SEQ_IRQ_ROUND_ROBIN_EN.
module tb_seq_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, t_clr, halt_req, run_req, ien_set, ien_clr;
  logic [3:0]  irq_flag, irq_mask;
  logic [3:0]  t_count;
  logic [15:0] t_onehot;
  logic        r_flag, running, ien, seq_overrun;
  logic [1:0]  irq_id;
  logic [11:0] irq_vec;
  logic [3:0]  int_ack;

  int checks   = 0;
  int failures = 0;

  seq_ctrl_unit dut (
    .clk(clk), .rst(rst), .t_clr(t_clr), .halt_req(halt_req), .run_req(run_req),
    .ien_set(ien_set), .ien_clr(ien_clr), .irq_flag(irq_flag), .irq_mask(irq_mask),
    .t_count(t_count), .t_onehot(t_onehot), .r_flag(r_flag), .running(running),
    .ien(ien), .irq_id(irq_id), .irq_vec(irq_vec), .int_ack(int_ack),
    .seq_overrun(seq_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_id;

  initial begin
    rst = 1'b1; t_clr = 0; halt_req = 0; run_req = 0; ien_set = 0; ien_clr = 0;
    irq_flag = '0; irq_mask = '0;
    tick(); tick();
    check("rst_tcount", 32'(t_count), 0);
    check("rst_onehot", 32'(t_onehot), 1);
    check("rst_running", 32'(running), 1);
    check("rst_rflag", 32'(r_flag), 0);
    check("rst_ien", 32'(ien), 0);
    check("rst_irq_id", 32'(irq_id), 0);
    check("rst_ack", 32'(int_ack), 0);
    check("rst_ovr", 32'(seq_overrun), 0);
    rst = 1'b0;

    // Instruction cycle T0..T3 ended by t_clr
    tick(); check("t1", 32'(t_count), 1);
    tick(); check("t2", 32'(t_count), 2);
    tick(); check("t3", 32'(t_count), 3);
    check("t3_onehot", 32'(t_onehot), 32'h0008);
    t_clr = 1; tick(); t_clr = 0;
    check("tclr_t0", 32'(t_count), 0);
    check("tclr_onehot", 32'(t_onehot), 1);

    // Interrupt entry at T4, channel 1 wins over 2
    ien_set = 1; tick(); ien_set = 0;
    check("ien_set", 32'(ien), 1);
    tick(); tick(); tick();
    check("at_t4", 32'(t_count), 4);
    irq_flag = 4'b0110; irq_mask = 4'b1111;
    tick();
    check("entry_r", 32'(r_flag), 1);
    check("entry_t", 32'(t_count), 0);
    check("entry_id", 32'(irq_id), 1);
    check("entry_vec", 32'(irq_vec), 12'h002);
    irq_flag = '0; t_clr = 1;
    tick(); t_clr = 0;
    check("r_t1_tclr_ignored", 32'(t_count), 1);
    check("r_t1_r", 32'(r_flag), 1);
    check("r_t1_vec_hold", 32'(irq_vec), 12'h002);
    tick();
    check("r_t2", 32'(t_count), 2);
    tick();
    check("exit_r", 32'(r_flag), 0);
    check("exit_t", 32'(t_count), 0);
    check("exit_ien", 32'(ien), 0);
    check("exit_ack", 32'(int_ack), 4'b0010);
    ien_set = 1; tick(); ien_set = 0;
    check("ack_pulse", 32'(int_ack), 0);
    check("ien_again", 32'(ien), 1);

    // Request raised at T1: no entry until the edge leaving T3; entry coincides with t_clr
    irq_flag = 4'b0001; irq_mask = 4'b1111;
    tick(); check("no_entry_t2", 32'(r_flag), 0);
    tick(); check("no_entry_t3", 32'(r_flag), 0);
    t_clr = 1; tick(); t_clr = 0; irq_flag = '0;
    check("late_entry_r", 32'(r_flag), 1);
    check("late_entry_t", 32'(t_count), 0);
    check("late_entry_id", 32'(irq_id), 0);
    check("late_entry_vec", 32'(irq_vec), 0);
    tick();
    halt_req = 1; tick(); halt_req = 0;
    check("halt_in_r_run", 32'(running), 1);
    check("halt_in_r_t", 32'(t_count), 2);
    tick();
    check("exit2_ack", 32'(int_ack), 4'b0001);

    // Masked request and disabled IEN never enter
    ien_set = 1; tick(); ien_set = 0;
    irq_flag = 4'b0001; irq_mask = 4'b0000;
    tick(); tick(); tick();
    check("masked_t4", 32'(t_count), 4);
    check("masked_r", 32'(r_flag), 0);
    ien_clr = 1; tick(); ien_clr = 0;
    check("ien_clr", 32'(ien), 0);
    irq_mask = 4'b1111;
    tick(); tick();
    check("ien_off_r", 32'(r_flag), 0);
    check("ien_off_t", 32'(t_count), 7);
    irq_flag = '0; irq_mask = '0;
    ien_set = 1; ien_clr = 1; tick(); ien_set = 0; ien_clr = 0;
    check("ien_both_clr", 32'(ien), 0);
    t_clr = 1; tick(); t_clr = 0;

    // Halt at T3, held while idle, then restart
    tick(); tick(); tick();
    halt_req = 1; tick(); halt_req = 0;
    check("halt_run", 32'(running), 0);
    check("halt_onehot", 32'(t_onehot), 0);
    ien_set = 1; irq_flag = 4'b0001; irq_mask = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted_run", 32'(running), 0);
      check("halted_onehot", 32'(t_onehot), 0);
      check("halted_r", 32'(r_flag), 0);
    end
    ien_set = 0; ien_clr = 1; irq_flag = '0; irq_mask = '0;
    tick(); ien_clr = 0;
    run_req = 1; tick();
    check("run_run", 32'(running), 1);
    check("run_onehot", 32'(t_onehot), 1);
    tick(); run_req = 0;
    check("run_while_running", 32'(t_count), 1);
    halt_req = 1; run_req = 1; tick(); halt_req = 0; run_req = 0;
    check("halt_wins", 32'(running), 0);
    run_req = 1; tick(); run_req = 0;
    check("rerun_t", 32'(t_count), 0);

    // Wrap without t_clr sets sticky overrun
    for (int i = 0; i < 15; i++) tick();
    check("t15", 32'(t_count), 15);
    check("t15_onehot", 32'(t_onehot), 32'h8000);
    check("t15_ovr", 32'(seq_overrun), 0);
    tick();
    check("wrap_t", 32'(t_count), 0);
    check("wrap_ovr", 32'(seq_overrun), 1);
    t_clr = 1; tick(); tick(); t_clr = 0;
    check("ovr_sticky", 32'(seq_overrun), 1);
    rst = 1; tick(); rst = 0;
    check("ovr_rst", 32'(seq_overrun), 0);

    // Repeated service with channels 0 and 1 both requesting
    for (int n = 0; n < 4; n++) begin
`ifdef SEQ_IRQ_ROUND_ROBIN_EN
      exp_id = n % 2;
`else
      exp_id = 0;
`endif
      ien_set = 1; tick(); ien_set = 0;
      irq_flag = 4'b0011; irq_mask = 4'b1111;
      tick(); tick(); tick();
      check("svc_r", 32'(r_flag), 1);
      check("svc_id", 32'(irq_id), 32'(exp_id));
      check("svc_vec", 32'(irq_vec), 32'(exp_id * 2));
      tick(); tick(); tick();
      check("svc_ack", 32'(int_ack), 32'(1 << exp_id));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
